// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers the operand beat, S2 registers result and flags.
// Latency: 2 cycles from acceptance to out_valid; full throughput while out_ready stays high.
// Backpressure: valid/ready; holds up to 2 beats when out_ready is low, in_ready drops when both stages are full.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);
    localparam int SHAMT = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBB  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_SLT  = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_XOR  = 4'd15;

    // Stage 1 holding registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;

    // Carry chained between arithmetic ops in acceptance order
    logic             cf;

    // Combinational results of the S1 -> S2 transfer
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] c_y;
    logic             c_carry;
    logic             c_ovf;
    logic             c_arith;
    logic [SHAMT-1:0] sh;

    logic             s2_adv;
    logic             s1_adv;

    // Handshake: S2 drains when empty or delivered; S1 moves forward whenever S2 does
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !rst && (!s1_valid || s1_adv);
    end

    // Operation decode and evaluation of the beat sitting in S1
    always_comb begin
        sum     = '0;
        c_y     = '0;
        c_carry = 1'b0;
        c_ovf   = 1'b0;
        c_arith = 1'b0;
        sh      = s1_b[SHAMT-1:0];
        case (s1_op)
            OP_ADD:  begin sum = {1'b0, s1_a} + {1'b0, s1_b}; c_arith = 1'b1; end
            OP_ADC:  begin sum = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, cf}; c_arith = 1'b1; end
            OP_SUB:  begin sum = {1'b0, s1_a} - {1'b0, s1_b}; c_arith = 1'b1; end
            OP_SBB:  begin sum = {1'b0, s1_a} - {1'b0, s1_b} - {{WIDTH{1'b0}}, cf}; c_arith = 1'b1; end
            OP_AND:  c_y = s1_a & s1_b;
            OP_OR:   c_y = s1_a | s1_b;
            OP_NOR:  c_y = ~(s1_a | s1_b);
            OP_XOR:  c_y = s1_a ^ s1_b;
            OP_SHL:  c_y = s1_a << sh;
            OP_SHR:  c_y = s1_a >> sh;
            OP_SRA:  c_y = $unsigned($signed(s1_a) >>> sh);
            // ~sh == WIDTH-1-sh, so the extra shift by one completes WIDTH-sh and
            // yields zero for sh==0, leaving operand_a unchanged
            OP_ROL:  c_y = (s1_a << sh) | ((s1_a >> ~sh) >> 1);
            OP_ROR:  c_y = (s1_a >> sh) | ((s1_a << ~sh) << 1);
            OP_EQ:   c_y = {{(WIDTH-1){1'b0}}, (s1_a == s1_b)};
            OP_SLT:  c_y = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU: c_y = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
            default: c_y = '0;
        endcase
        if (c_arith) begin
            c_y     = sum[WIDTH-1:0];
            c_carry = sum[WIDTH];
            if (s1_op == OP_ADD || s1_op == OP_ADC)
                c_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (c_y[WIDTH-1] != s1_a[WIDTH-1]);
            else
                c_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (c_y[WIDTH-1] != s1_a[WIDTH-1]);
        end
    end

    // Stage 1: capture an accepted beat, empty when it moves on with nothing behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_a     <= operand_a;
            s1_b     <= operand_b;
            s1_op    <= opcode;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register result and flags; frozen while the output is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y        <= c_y;
                carry    <= c_carry;
                zero     <= (c_y == '0);
                overflow <= c_ovf;
            end
        end
    end

    // Carry flag follows every arithmetic op as it leaves S1
    always_ff @(posedge clk) begin
        if (rst)
            cf <= 1'b0;
        else if (s1_adv && c_arith)
            cf <= c_carry;
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe (WIDTH=8) against a scoreboard of expected beats.
// Expected results come from spec constants or an independent integer reference model.
// Output is sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       carry;
    logic       zero;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int m_cf   = 0;
    bit rand_bp = 1'b0;
    logic [10:0] sb[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Integer reference model; returns {y, carry, zero, overflow}
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output logic [10:0] r);
        int ua, ub, sa, sbv, res, sres, sh, cin;
        logic [7:0] yy;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sbv = $signed(b); sh = b[2:0];
        c = 1'b0; v = 1'b0; yy = 8'h00;
        cin = (op == 4'd8 || op == 4'd9) ? m_cf : 0;
        case (op)
            4'd0, 4'd8: begin
                res = ua + ub + cin; sres = sa + sbv + cin;
                yy = res[7:0]; c = (res > 255); v = (sres > 127) || (sres < -128); m_cf = c;
            end
            4'd1, 4'd9: begin
                res = ua - ub - cin; sres = sa - sbv - cin;
                yy = res[7:0]; c = (res < 0); v = (sres > 127) || (sres < -128); m_cf = c;
            end
            4'd2:  yy = a & b;
            4'd3:  yy = a | b;
            4'd4:  yy = ~(a | b);
            4'd5:  begin res = ua << sh; yy = res[7:0]; end
            4'd6:  begin res = ua >> sh; yy = res[7:0]; end
            4'd7:  yy = (a == b) ? 8'd1 : 8'd0;
            4'd10: begin res = sa >>> sh; yy = res[7:0]; end
            4'd11: begin yy = a; repeat (sh) yy = {yy[6:0], yy[7]}; end
            4'd12: begin yy = a; repeat (sh) yy = {yy[0], yy[7:1]}; end
            4'd13: yy = (sa < sbv) ? 8'd1 : 8'd0;
            4'd14: yy = (ua < ub) ? 8'd1 : 8'd0;
            default: yy = a ^ b;
        endcase
        r = {yy, c, (yy == 8'h00), v};
    endtask

    // Present one beat and hold it until accepted; push its expected result
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input bit use_exp, input logic [10:0] exp_v, input bit push);
        logic [10:0] m;
        bit ok;
        ok = 1'b0;
        operand_a = a; operand_b = b; opcode = op; in_valid = 1'b1;
        model(a, b, op, m);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        if (ok && push) sb.push_back(use_exp ? exp_v : m);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Scoreboard: every delivered beat must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) chk("sb_unexpected_beat", 32'(sb.size()), 32'd1);
            else chk("sb_result", {21'd0, y, carry, zero, overflow}, {21'd0, sb.pop_front()});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ba [4];
        logic [7:0]  bb [4];
        logic [3:0]  bo [4];
        logic [10:0] m;
        int idx;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        operand_a = 8'h00; operand_b = 8'h00; opcode = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", {21'd0, y, carry, zero, overflow}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency and ADD wrap, then ADC/SBB chaining on cf
        send(8'hFF, 8'h01, 4'd0, 1, {8'h00, 1'b1, 1'b1, 1'b0}, 1);
        @(negedge clk); chk("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        send(8'hFF, 8'h01, 4'd0, 1, {8'h00, 1'b1, 1'b1, 1'b0}, 1);
        send(8'h00, 8'h00, 4'd8, 1, {8'h01, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h05, 8'h01, 4'd9, 1, {8'h04, 1'b0, 1'b0, 1'b0}, 1);
        // Subtraction overflow and borrow
        send(8'h80, 8'h01, 4'd1, 1, {8'h7F, 1'b0, 1'b0, 1'b1}, 1);
        send(8'h00, 8'h01, 4'd1, 1, {8'hFF, 1'b1, 1'b0, 1'b0}, 1);
        // Shifts, rotates and compares
        send(8'h80, 8'h03, 4'd10, 1, {8'hF0, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h81, 8'h01, 4'd11, 1, {8'h03, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h01, 8'h01, 4'd12, 1, {8'h80, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h80, 8'h01, 4'd13, 1, {8'h01, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h80, 8'h01, 4'd14, 1, {8'h00, 1'b0, 1'b1, 1'b0}, 1);
        send(8'hA5, 8'h08, 4'd11, 1, {8'hA5, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h3C, 8'h3C, 4'd7, 1, {8'h01, 1'b0, 1'b0, 1'b0}, 1);
        send(8'h7F, 8'h01, 4'd0, 1, {8'h80, 1'b0, 1'b0, 1'b1}, 1);
        repeat (4) @(posedge clk); #1;
        chk("drain1_queue_empty", 32'(sb.size()), 32'd0);

        // Stall: four beats offered with out_ready low, only two fit
        ba[0] = 8'h01; bb[0] = 8'h02; bo[0] = 4'd0;
        ba[1] = 8'h0F; bb[1] = 8'hF0; bo[1] = 4'd15;
        ba[2] = 8'h10; bb[2] = 8'h01; bo[2] = 4'd3;
        ba[3] = 8'hF0; bb[3] = 8'h3C; bo[3] = 4'd2;
        out_ready = 1'b0; idx = 0;
        operand_a = ba[0]; operand_b = bb[0]; opcode = bo[0]; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model(ba[idx], bb[idx], bo[idx], m);
                sb.push_back(m);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) begin operand_a = ba[idx]; operand_b = bb[idx]; opcode = bo[idx]; end
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_y_held", 32'(y), 32'h03);
        @(negedge clk);
        chk("stall_y_stable", 32'(y), 32'h03);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(ba[2], bb[2], bo[2], 0, 11'd0, 1);
        send(ba[3], bb[3], bo[3], 0, 11'd0, 1);
        repeat (4) @(posedge clk); #1;
        chk("drain2_queue_empty", 32'(sb.size()), 32'd0);

        // Reset with two beats in flight; cf must be cleared
        out_ready = 1'b0;
        send(8'hFF, 8'h01, 4'd0, 0, 11'd0, 0);
        send(8'hFF, 8'h01, 4'd0, 0, 11'd0, 0);
        operand_a = 8'h55; operand_b = 8'h55; opcode = 4'd0; in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; m_cf = 0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_cf", 32'(dut.cf), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(8'h01, 8'h01, 4'd8, 1, {8'h02, 1'b0, 1'b0, 1'b0}, 1);

        // Random traffic with random output backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 80; i++)
            send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 0, 11'd0, 1);
        rand_bp = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
